clock_counter_arbiter: RTL and testbench

Shares the single 64-bit clock counter CSR slave among NUM_PORTS Nios cores. It presents one Avalon-MM slave port per core and one Avalon-MM master port to the counter. Each read of the low word issues an atomic, uninterruptible low-then-high pair of reads on the master side, and stores the high word in a per-port snapshot. This keeps each core's 64-bit reading coherent even when other cores read the counter at the same time.

---
 rtl/clock_counter_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/clock_counter_arbiter.sv | 140 ++++++++++++++
 tb/tb_clock_counter_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_counter_pkg.sv
// Shared types and constants for the clock counter arbiter.
// Master-port addresses, data width and arbiter FSM states.
package clock_counter_pkg;

  localparam int   CC_DATA_W  = 32;
  localparam logic CC_ADDR_LO = 1'b0;
  localparam logic CC_ADDR_HI = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    RD_DONE,
    WR
  } cc_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal last-grant pointer.
// Ports: clock, reset, req[N], advance in; one-hot grant[N] out.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic          found;

  // Scan from the port after last, wrapping, first hit wins.
  always_comb begin
    grant = '0;
    pick  = last;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        pick       = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last <= IW'(N - 1);
    end else if (advance && found) begin
      last <= pick;
    end
  end

endmodule

// File: rtl/clock_counter_arbiter.sv
// Shares one 64-bit clock counter CSR among NUM_PORTS cores.
// Ports: per-core Avalon slaves s_*, one Avalon master m_* to the CSR.
module clock_counter_arbiter
  import clock_counter_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                s_read,
  input  logic [NUM_PORTS-1:0]                s_write,
  input  logic [NUM_PORTS-1:0]                s_address,
  input  logic [NUM_PORTS-1:0][CC_DATA_W-1:0] s_writedata,
  output logic [NUM_PORTS-1:0][CC_DATA_W-1:0] s_readdata,
  output logic [NUM_PORTS-1:0]                s_waitrequest,
  output logic                                m_read,
  output logic                                m_write,
  output logic                                m_address,
  output logic [CC_DATA_W-1:0]                m_writedata,
  input  logic [CC_DATA_W-1:0]                m_readdata
);

  localparam int IW = $clog2(NUM_PORTS);

  cc_arb_state_t state;
  cc_arb_state_t state_n;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] mreq;
  logic [NUM_PORTS-1:0] hreq;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] ack;
  logic [IW-1:0]        gidx;
  logic [IW-1:0]        gsel;
  logic [CC_DATA_W-1:0] lo_buf;

  logic [NUM_PORTS-1:0][CC_DATA_W-1:0] snap;
  logic [NUM_PORTS-1:0][CC_DATA_W-1:0] rdata;

  // Write wins over read; high-word reads never touch the master.
  assign req  = s_read | s_write;
  assign mreq = s_write | (s_read & ~s_address);
  assign hreq = s_read & ~s_write & s_address;

  assign s_waitrequest = req & ~ack;

  rr_arbiter #(
    .N(NUM_PORTS)
  ) u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    (mreq),
    .advance(state == IDLE),
    .grant  (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) gidx = IW'(i);
    end
  end

  always_comb begin
    state_n     = state;
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_address   = CC_ADDR_LO;
    m_writedata = '0;
    unique case (state)
      IDLE: begin
        if (|mreq) state_n = s_write[gidx] ? WR : RD_LO;
      end
      RD_LO: begin
        m_read  = 1'b1;
        state_n = RD_HI;
      end
      RD_HI: begin
        m_read    = 1'b1;
        m_address = CC_ADDR_HI;
        state_n   = RD_DONE;
      end
      RD_DONE: begin
        state_n = IDLE;
      end
      WR: begin
        m_write     = 1'b1;
        m_address   = s_address[gsel];
        m_writedata = s_writedata[gsel];
        state_n     = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // The low word is only presented during RD_DONE.
  always_comb begin
    s_readdata = rdata;
    if (state == RD_DONE) s_readdata[gsel] = lo_buf;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gsel   <= '0;
      lo_buf <= '0;
      snap   <= '0;
      rdata  <= '0;
      ack    <= '0;
    end else begin
      state <= state_n;
      // Local high-word reads: one wait state, then a one-cycle ack.
      ack <= hreq & ~ack;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (hreq[i] && !ack[i]) rdata[i] <= snap[i];
      end
      unique case (state)
        IDLE: begin
          if (|mreq) begin
            gsel <= gidx;
            if (s_write[gidx]) ack[gidx] <= 1'b1;
          end
        end
        RD_HI: begin
          lo_buf <= m_readdata;
          // A requester that walked away gets no ack.
          if (mreq[gsel]) ack[gsel] <= 1'b1;
        end
        RD_DONE: begin
          snap[gsel] <= m_readdata;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_counter_arbiter.sv
// Randomized self-checking bench for clock_counter_arbiter.
// Counter CSR model plus per-port Avalon request scoreboard.
module tb_clock_counter_arbiter;

  localparam int N = 4;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0]        s_read = '0;
  logic [N-1:0]        s_write = '0;
  logic [N-1:0]        s_address = '0;
  logic [N-1:0][31:0]  s_writedata = '0;
  logic [N-1:0][31:0]  s_readdata;
  logic [N-1:0]        s_waitrequest;
  logic                m_read;
  logic                m_write;
  logic                m_address;
  logic [31:0]         m_writedata;
  logic [31:0]         m_readdata = '0;

  always #5 clock = ~clock;

  clock_counter_arbiter #(
    .NUM_PORTS(N)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_address    (s_address),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .s_waitrequest(s_waitrequest),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata)
  );

  // Counter CSR: free-running, low-word read latches the high word.
  logic [63:0] cnt = 64'h0000_0005_FFFF_FFE0;
  logic [31:0] hold = '0;
  int          cyc = 0;
  logic [63:0] hist [64];

  always @(posedge clock) begin
    if (m_read) begin
      if (!m_address) begin
        m_readdata <= cnt[31:0];
        hold       <= cnt[63:32];
      end else begin
        m_readdata <= hold;
      end
    end
    if (m_write) cnt <= 64'd0;
    else cnt <= cnt + 64'd1;
    cyc <= cyc + 1;
  end

  always @(negedge clock) hist[cyc & 63] <= cnt;

  typedef enum int {OP_LO, OP_HI, OP_WR, OP_RW} op_e;

  typedef struct {
    int          port;
    int          at;
    op_e         op;
    logic        addr;
    logic [31:0] wd;
    int          exp_wait;
  } op_t;

  op_t         q[$];
  op_t         cur [N];
  bit          act [N];
  int          st [N];
  logic [31:0] snapm [N];
  int          n_pass = 0;
  int          n_chk = 0;
  int          n_mrd = 0;
  int          n_mwr = 0;
  bit          prev_lo = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic add(input int p, input int at, input op_e op,
                     input logic [31:0] wd, input int ew);
    op_t o;
    o.port     = p;
    o.at       = at;
    o.op       = op;
    o.addr     = (op == OP_HI) ? 1'b1 : (op == OP_LO) ? 1'b0 : wd[0];
    o.wd       = wd;
    o.exp_wait = ew;
    q.push_back(o);
  endtask

  task automatic finish_op(input int p);
    logic [63:0] h;
    int          w;
    int          bound;
    w = cyc - st[p];
    case (cur[p].op)
      OP_LO: begin
        h = hist[(cyc - 2) & 63];
        chk($sformatf("p%0d lo data", p), 64'(s_readdata[p]), 64'(h[31:0]));
        snapm[p] = h[63:32];
        bound = (N - 1) * 4 + 3;
      end
      OP_HI: begin
        chk($sformatf("p%0d hi data", p), 64'(s_readdata[p]), 64'(snapm[p]));
        bound = 1;
      end
      default: begin
        chk($sformatf("p%0d wr strobe", p), 64'(m_write), 64'd1);
        chk($sformatf("p%0d wr data", p), 64'(m_writedata), 64'(cur[p].wd));
        chk($sformatf("p%0d wr addr", p), 64'(m_address), 64'(cur[p].addr));
        bound = (N - 1) * 4 + 1;
      end
    endcase
    if (cur[p].exp_wait >= 0)
      chk($sformatf("p%0d waits", p), 64'(w), 64'(cur[p].exp_wait));
    else
      chk($sformatf("p%0d wait bound", p), 64'(w <= bound), 64'd1);
  endtask

  task automatic run(input int budget);
    int                 t;
    bit                 busy;
    logic [N-1:0]       nr;
    logic [N-1:0]       nw;
    logic [N-1:0]       na;
    logic [N-1:0][31:0] nd;
    t = 0;
    do begin
      @(negedge clock);
      if (prev_lo) chk("lo/hi pair", 64'({m_read, m_address}), 64'd3);
      prev_lo = m_read && !m_address;
      if (m_read) n_mrd++;
      if (m_write) n_mwr++;
      nr = s_read;
      nw = s_write;
      na = s_address;
      nd = s_writedata;
      for (int p = 0; p < N; p++) begin
        if (act[p]) begin
          if (!s_waitrequest[p]) begin
            finish_op(p);
            act[p] = 1'b0;
            nr[p]  = 1'b0;
            nw[p]  = 1'b0;
          end
        end else begin
          for (int i = 0; i < q.size(); i++) begin
            if (q[i].port == p) begin
              if (q[i].at <= t) begin
                cur[p] = q[i];
                q.delete(i);
                act[p] = 1'b1;
                st[p]  = cyc + 1;
                nr[p]  = (cur[p].op != OP_WR);
                nw[p]  = (cur[p].op == OP_WR) || (cur[p].op == OP_RW);
                na[p]  = cur[p].addr;
                nd[p]  = cur[p].wd;
              end
              break;
            end
          end
        end
      end
      @(posedge clock);
      #1;
      s_read      = nr;
      s_write     = nw;
      s_address   = na;
      s_writedata = nd;
      t++;
      busy = (q.size() != 0);
      for (int p = 0; p < N; p++) busy |= act[p];
    end while (busy && t < budget);
    chk("run completes", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    s_read      = '0;
    s_write     = '0;
    s_address   = '0;
    s_writedata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst waitrequest", 64'(s_waitrequest), 64'd0);
    chk("rst m_read", 64'(m_read), 64'd0);
    chk("rst m_write", 64'(m_write), 64'd0);
    chk("rst m_address", 64'(m_address), 64'd0);
    chk("rst m_writedata", 64'(m_writedata), 64'd0);
    for (int p = 0; p < N; p++) begin
      chk($sformatf("rst rdata p%0d", p), 64'(s_readdata[p]), 64'd0);
      snapm[p] = '0;
      act[p]   = 1'b0;
    end
    reset   = 1'b0;
    prev_lo = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int          w0;
    int          r0;
    int          n;
    int          at;
    op_e         op;
    logic [63:0] h;

    do_reset();
    add(0, 0, OP_LO, '0, 3);
    add(0, 0, OP_HI, '0, 1);
    run(100);

    do_reset();
    for (int p = 0; p < N; p++) add(p, 0, OP_LO, '0, 3 + 4 * p);
    for (int p = 0; p < N; p++) add(p, 0, OP_HI, '0, 1);
    run(200);

    add(2, 0, OP_LO, '0, 3);
    add(1, 1, OP_HI, '0, 1);
    run(100);

    w0 = n_mwr;
    add(2, 0, OP_WR, 32'hDEAD_BEEF, 5);
    add(0, 0, OP_LO, '0, 3);
    add(0, 0, OP_HI, '0, 1);
    for (int p = 1; p < N; p++) add(p, 8, OP_HI, '0, 1);
    run(100);
    chk("single m_write", 64'(n_mwr - w0), 64'd1);

    w0 = n_mwr;
    r0 = n_mrd;
    add(3, 0, OP_RW, $urandom, 1);
    run(50);
    chk("rw write count", 64'(n_mwr - w0), 64'd1);
    chk("rw read count", 64'(n_mrd - r0), 64'd0);

    s_read[0]    = 1'b1;
    s_address[0] = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    chk("rd_hi strobe", 64'({m_read, m_address}), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("async m_read", 64'(m_read), 64'd0);
    chk("async m_write", 64'(m_write), 64'd0);
    chk("async m_address", 64'(m_address), 64'd0);
    chk("async wait p0", 64'(s_waitrequest[0]), 64'd1);
    for (int p = 0; p < N; p++) begin
      chk($sformatf("async rdata p%0d", p), 64'(s_readdata[p]), 64'd0);
      snapm[p] = '0;
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    r0    = cyc;
    n     = 0;
    do begin
      @(negedge clock);
      n++;
    end while (s_waitrequest[0] && n < 20);
    h = hist[(cyc - 2) & 63];
    chk("reserve waits", 64'(cyc - r0), 64'd3);
    chk("reserve data", 64'(s_readdata[0]), 64'(h[31:0]));
    snapm[0] = h[63:32];
    @(posedge clock);
    #1;
    s_read[0] = 1'b0;
    prev_lo   = 1'b0;
    add(0, 0, OP_HI, '0, 1);
    add(1, 0, OP_HI, '0, 1);
    run(50);

    for (int p = 0; p < N; p++) begin
      at = 0;
      repeat (50) begin
        at += $urandom_range(0, 5);
        op = op_e'($urandom_range(0, 3));
        add(p, at, op, $urandom, (op == OP_HI) ? 1 : -1);
      end
    end
    run(5000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
